// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, FSM state encoding and access-size helpers
// for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    SPLIT  = 2'd2,
    RESP   = 2'd3
  } lsu_state_e;

  // Access size in bytes: 1, 2, 4 or 8.
  function automatic logic [3:0] access_size(input logic [2:0] funct3);
    return 4'd1 << funct3[1:0];
  endfunction

  // True when the address is not a multiple of the access size.
  function automatic logic is_misaligned(input logic [2:0] addr_lo,
                                         input logic [2:0] funct3);
    logic [3:0] mask;
    mask = access_size(funct3) - 4'd1;
    return ({1'b0, addr_lo} & mask) != 4'd0;
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// lsu_extend: sign/zero extension of a byte-assembled load value,
// selected by funct3. Purely combinational.
module lsu_extend
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0] raw_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] ext_o
);

  // Extend from the top bit of the access width.
  always_comb begin
    ext_o = raw_i;
    case (funct3_i)
      F3_B:    ext_o = {{(XLEN-8){raw_i[7]}}, raw_i[7:0]};
      F3_H:    ext_o = {{(XLEN-16){raw_i[15]}}, raw_i[15:0]};
      F3_W:    ext_o = {{(XLEN-32){raw_i[31]}}, raw_i[31:0]};
      F3_BU:   ext_o = {{(XLEN-8){1'b0}}, raw_i[7:0]};
      F3_HU:   ext_o = {{(XLEN-16){1'b0}}, raw_i[15:0]};
      F3_WU:   ext_o = {{(XLEN-32){1'b0}}, raw_i[31:0]};
      default: ext_o = raw_i;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit between execute and the unified mem block.
// One request per handshake, response on a valid/ready channel.
// Optional feature macro: LSU_MISALIGNED_SPLIT_EN -- when defined,
// misaligned accesses are split into sequential byte accesses; otherwise
// they fault without touching memory.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_fault,
  output logic [XLEN-1:0] mem_addr,
  output logic [2:0]      mem_width,
  output logic            mem_we,
  inout  wire  [XLEN-1:0] mem_data
);

  lsu_state_e      state_q, state_d;
  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            fault_q, fault_d;
  logic [XLEN-1:0] mem_dout;

`ifdef LSU_MISALIGNED_SPLIT_EN
  logic [2:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] asm_val;
  logic [XLEN-1:0] ext_val;

  // rdata_q doubles as the raw byte accumulator while splitting.
  always_comb begin
    asm_val = rdata_q;
    asm_val[{cnt_q, 3'b000} +: 8] = mem_data[7:0];
  end

  lsu_extend #(.XLEN(XLEN)) u_extend (
    .raw_i    (asm_val),
    .funct3_i (f3_q),
    .ext_o    (ext_val)
  );
`endif

  // Bus is driven only during write cycles; mem_we is decoded from state,
  // so an asynchronous reset releases it immediately.
  assign mem_data   = mem_we ? mem_dout : {XLEN{1'bz}};
  assign resp_rdata = rdata_q;
  assign resp_fault = fault_q;

  // Next-state, register updates and memory/handshake outputs.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    f3_d       = f3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    fault_d    = fault_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_addr   = '0;
    mem_width  = F3_B;
    mem_we     = 1'b0;
    mem_dout   = '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          fault_d = 1'b0;
          if (req_funct3 == 3'b111 || (req_we && req_funct3[2])) begin
            fault_d = 1'b1;
            state_d = RESP;
          end else if (is_misaligned(req_addr[2:0], req_funct3)) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
            cnt_d   = '0;
            state_d = SPLIT;
`else
            fault_d = 1'b1;
            state_d = RESP;
`endif
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        mem_addr  = addr_q;
        mem_width = f3_q;
        mem_we    = we_q;
        mem_dout  = wdata_q;
        if (!we_q) rdata_d = mem_data;
        state_d = RESP;
      end
`ifdef LSU_MISALIGNED_SPLIT_EN
      SPLIT: begin
        mem_addr = addr_q + XLEN'(cnt_q);
        if (we_q) begin
          mem_width = F3_B;
          mem_we    = 1'b1;
          mem_dout  = XLEN'(wdata_q[{cnt_q, 3'b000} +: 8]);
        end else begin
          mem_width = F3_BU;
          rdata_d   = asm_val;
        end
        if ({1'b0, cnt_q} == access_size(f3_q) - 4'd1) begin
          if (!we_q) rdata_d = ext_val;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
`endif
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and request registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
`ifdef LSU_MISALIGNED_SPLIT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
`ifdef LSU_MISALIGNED_SPLIT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: scoreboard bench for lsu with a byte-array mem fixture and a
// byte-level reference model of the load/store rules.
module tb_lsu;

`ifdef LSU_MISALIGNED_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_fault;
  logic [63:0] resp_rdata, mem_addr;
  logic [2:0]  mem_width;
  logic        mem_we;
  wire  [63:0] mem_data;

  lsu #(.XLEN(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_addr(mem_addr), .mem_width(mem_width), .mem_we(mem_we),
    .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] rdata;
    logic        fault;
    int unsigned lat;
    int unsigned wes;
    int unsigned acc;
  } exp_t;
  exp_t sbq[$];

  // ---------------- mem fixture ----------------
  logic [7:0]  ref_mem [64];
  logic [7:0]  fmem    [64];
  bit          load_img = 1'b0;
  bit          quiet    = 1'b1;
  logic [63:0] rd_val;

  always_comb begin
    int unsigned sz;
    logic [5:0]  idx;
    rd_val = '0;
    sz = 1 << mem_width[1:0];
    for (int unsigned k = 0; k < 8; k++) begin
      idx = mem_addr[5:0] + 6'(k);
      if (k < sz) rd_val[8*k +: 8] = fmem[idx];
    end
    if (!mem_width[2] && sz < 8 && rd_val[8*sz-1])
      for (int unsigned k = 0; k < 8; k++)
        if (k >= sz) rd_val[8*k +: 8] = 8'hFF;
  end

  assign mem_data = (!mem_we && !quiet) ? rd_val : 64'bz;

  always @(posedge clk) begin
    if (load_img) begin
      for (int k = 0; k < 64; k++) fmem[k] <= ref_mem[k];
    end else if (mem_we) begin
      for (int unsigned k = 0; k < (1 << mem_width[1:0]); k++)
        fmem[6'(mem_addr[5:0] + 6'(k))] <= mem_data[8*k +: 8];
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out", name);
  endtask

  // Reference model: byte-array semantics straight from the funct3 rules.
  task automatic predict(input bit we, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wd, output exp_t e);
    int unsigned size;
    bit illegal, mis;
    size    = 1 << f3[1:0];
    illegal = (f3 == 3'b111) || (we && f3[2]);
    mis     = (addr % size) != 0;
    e.rdata = '0; e.fault = 1'b0; e.lat = 0; e.wes = 0; e.acc = 0;
    if (illegal || (mis && !SPLIT_EN)) begin
      e.fault = 1'b1;
      return;
    end
    e.lat = mis ? size : 1;
    if (we) begin
      e.wes = mis ? size : 1;
      for (int unsigned k = 0; k < size; k++)
        ref_mem[int'((addr + k) % 64)] = wd[8*k +: 8];
    end else begin
      for (int unsigned k = 0; k < size; k++)
        e.rdata[8*k +: 8] = ref_mem[int'((addr + k) % 64)];
      if (!f3[2] && size < 8 && e.rdata[8*size-1])
        e.rdata = e.rdata | ({64{1'b1}} << (8*size));
    end
  endtask

  task automatic issue(input bit we, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wd);
    exp_t e;
    int n;
    @(negedge clk);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    if (!req_ready) begin
      fail_timeout("req_ready");
      req_valid = 1'b0;
      return;
    end
    predict(we, f3, addr, wd, e);
    e.acc = cyc + 1;
    sbq.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 2000) begin @(negedge clk); n++; end
    if (sbq.size() != 0) begin
      fail_timeout("response drain");
      sbq.delete();
    end
  endtask

  // ---------------- resp_ready driver ----------------
  int unsigned bp_hold = 0;
  bit          rnd_ready = 1'b0;
  initial begin
    resp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_hold > 0) begin
        resp_ready = 1'b0;
        if (resp_valid) bp_hold--;
      end else begin
        resp_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // ---------------- monitor ----------------
  bit          seen = 1'b0;
  int unsigned first_cyc, wecnt = 0;
  logic [63:0] r0;
  logic        f0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      seen = 1'b0;
      wecnt = 0;
    end else begin
      if (mem_we) wecnt++;
      if (resp_valid) begin
        chk("req_ready low during resp", {63'd0, req_ready}, 64'd0);
        if (!seen) begin
          seen = 1'b1; first_cyc = cyc; r0 = resp_rdata; f0 = resp_fault;
        end else begin
          chk("resp_rdata stable", resp_rdata, r0);
          chk("resp_fault stable", {63'd0, resp_fault}, {63'd0, f0});
        end
        if (resp_ready) begin
          if (sbq.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected response: rdata %h fault %0d, none expected",
                     resp_rdata, resp_fault);
          end else begin
            e = sbq.pop_front();
            chk("resp_rdata", resp_rdata, e.rdata);
            chk("resp_fault", {63'd0, resp_fault}, {63'd0, e.fault});
            chk("latency", 64'(first_cyc - e.acc), 64'(e.lat));
            chk("mem_we cycles", 64'(wecnt), 64'(e.wes));
          end
          seen = 1'b0;
          wecnt = 0;
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] drv, wd, a;
    logic [2:0]  f3;
    bit          we;
    int          n;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0;
    for (int k = 0; k < 64; k++) ref_mem[k] = 8'($urandom);
    for (int k = 0; k < 8; k++) begin
      drv = 64'h8877665544332211; ref_mem[k]     = drv[8*k +: 8];
      drv = 64'hFFEEDDCCBBAA9900; ref_mem[8 + k] = drv[8*k +: 8];
    end
    load_img = 1'b1;
    @(posedge clk);
    #1 load_img = 1'b0;

    @(negedge clk);
    chk("reset req_ready",  {63'd0, req_ready},  64'd1);
    chk("reset resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("reset resp_fault", {63'd0, resp_fault}, 64'd0);
    chk("reset resp_rdata", resp_rdata, 64'd0);
    chk("reset mem_we",     {63'd0, mem_we},     64'd0);
    chk("reset mem_addr",   mem_addr, 64'd0);
    chk("reset mem_width",  {61'd0, mem_width},  64'd0);
    rst = 1'b0;
    quiet = 1'b0;

    // Directed: aligned loads, store/load, misaligned, illegal.
    issue(0, 3'b011, 64'd0, '0);
    issue(0, 3'b000, 64'd7, '0);
    issue(0, 3'b100, 64'd7, '0);
    issue(1, 3'b010, 64'd0, 64'hAAAAAAAABBBBBBBB);
    issue(0, 3'b011, 64'd0, '0);
    issue(0, 3'b001, 64'd7, '0);
    issue(0, 3'b010, 64'd6, '0);
    issue(0, 3'b111, 64'd8, '0);
    issue(1, 3'b100, 64'd8, 64'h55);
    issue(0, 3'b011, 64'd1, '0);
    drain();

    // Backpressure: resp_ready low while response is held.
    bp_hold = 5;
    issue(0, 3'b011, 64'd8, '0);
    drain();

    // Randomized traffic with random resp_ready.
    rnd_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      we = 1'($urandom);
      f3 = 3'($urandom);
      a  = 64'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 0) a = a & ~64'((1 << f3[1:0]) - 1);
      issue(we, f3, a, {$urandom, $urandom});
    end
    drain();
    rnd_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset in the middle of a store.
    quiet = 1'b1;
    if (SPLIT_EN) begin
      we = 1; f3 = 3'b001; a = 64'd1; wd = 64'h000000000000A5C3;
    end else begin
      we = 1; f3 = 3'b011; a = 64'd16; wd = 64'h1122334455667788;
    end
    @(negedge clk);
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) fail_timeout("req_ready before reset test");
    @(posedge clk);
    #1 req_valid = 1'b0;
    if (SPLIT_EN) begin
      @(posedge clk);
      #1;
      drv = {56'd0, wd[15:8]};
    end else begin
      drv = wd;
    end
    #2;
    chk("mem_we before reset", {63'd0, mem_we}, 64'd1);
    rst = 1'b1;
    #1;
    chk("mem_we async drop", {63'd0, mem_we}, 64'd0);
    chk("bus released", {63'd0, (mem_data === drv)}, 64'd0);
    chk("resp_valid in reset", {63'd0, resp_valid}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    quiet = 1'b0;
    if (SPLIT_EN) ref_mem[1] = wd[7:0];
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("req_ready after reset", {63'd0, req_ready}, 64'd1);
      chk("no resp after reset", {63'd0, resp_valid}, 64'd0);
    end

    // Memory keeps only the bytes written before reset.
    issue(0, 3'b011, 64'd0, '0);
    issue(0, 3'b011, 64'd16, '0);
    drain();
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/lsu.md
# lsu

- Load/store unit between the execute stage and the unified `mem` block.
- Accepts one load or store per handshake and drives `mem`'s address, width and write-enable, plus the shared bidirectional 64-bit data bus.
- Returns load data, or a fault indication, on a valid/ready response channel.
- Optionally splits misaligned accesses into sequential byte accesses.

## Interface
- `XLEN`, default 64: data and address width. Must equal the `BITS` of the attached `mem`.
- `clk` in 1: clock. All state changes on the rising edge.
- `rst` in 1: asynchronous reset, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: LSU can accept a request. High only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RISC-V funct3. 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
- `req_addr` in XLEN: byte address.
- `req_wdata` in XLEN: store data, right-aligned.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer takes the response.
- `resp_rdata` out XLEN: load result, already extended. 0 for stores and faults.
- `resp_fault` out 1: illegal funct3, or misaligned access without split support.
- `mem_addr` out XLEN: address to `mem`.
- `mem_width` out 3: width code to `mem`, same encoding as funct3.
- `mem_we` out 1: write enable to `mem`.
- `mem_data` inout XLEN: shared data bus.
  - Driven by the LSU only while `mem_we`=1; otherwise high-Z.
  - Read data from `mem` is valid combinationally within the access cycle.

## Operation
- **Reset values:**
  - `req_ready`=1.
  - `resp_valid`=0, `resp_fault`=0, `resp_rdata`=0.
  - `mem_we`=0, `mem_addr`=0, `mem_width`=000.
  - `mem_data` high-Z.
  - State = IDLE.
- **IDLE.** On `req_valid&&req_ready`, register the request. Access size = 1<<funct3[1:0]. Next state:
  - `resp_fault` path to RESP (no memory access) if:
    - funct3=111, or
    - `req_we`=1 with funct3[2]=1.
  - If the address is misaligned (addr mod size ≠ 0): SPLIT when the split macro is defined; otherwise RESP with `resp_fault`=1.
  - Otherwise: ACCESS.
- **ACCESS** (one cycle):
  - Drive `mem_addr`=addr, `mem_width`=funct3, `mem_we`=we.
  - Store: drive wdata on `mem_data`.
  - Load: capture `mem_data` at the closing edge. `mem` performs the extension.
  - Next state: RESP.
- **SPLIT** (one cycle per byte, k = 0..size-1):
  - Drive `mem_addr`=addr+k, with XLEN-bit wrap-around.
  - Load: `mem_width`=100; capture `mem_data[7:0]` into byte k.
  - Store: `mem_width`=000, `mem_we`=1; drive byte k of wdata on `mem_data[7:0]`.
  - After k=size-1, go to RESP.
  - In RESP, signed loads are sign-extended from bit 8·size-1; unsigned loads are zero-extended.
- **RESP:**
  - `resp_valid`=1; `resp_rdata` and `resp_fault` are held stable until `resp_ready`.
  - On `resp_ready`, go to IDLE.
  - `req_ready` is 0 outside IDLE, so there is no overlap of request and response.
- `mem_we` is 0 in IDLE and RESP.

## Timing
- Request accepted at edge E.
- **Aligned:** ACCESS runs in cycle E..E+1; `resp_valid` is high after E+1. Latency is 2 edges to the earliest completion.
- **Split:** size access cycles, then RESP. An LD at addr 1 takes 8 memory cycles.
- **Zero-bubble back-to-back:** `resp_ready`=1 and `req_valid`=1 together give a new accept on the edge after RESP→IDLE. The minimum issue interval is 3 cycles aligned.
- **Reset mid-operation** (any state):
  - `mem_we` drops and `mem_data` releases immediately, asynchronously.
  - Any pending response is discarded.
  - A partial split store leaves the already-written bytes in memory.

## Configuration
- `LSU_MISALIGNED_SPLIT_EN`:
  - **Defined:** misaligned accesses are performed via SPLIT as above.
  - **Undefined:** SPLIT state and byte counter are absent; misaligned accesses complete through RESP with `resp_fault`=1, `resp_rdata`=0 and no memory cycle.

## Structure
- `lsu_pkg` holds:
  - funct3 localparams (F3_B … F3_WU).
  - State encoding: IDLE, ACCESS, SPLIT, RESP.
  - Size-from-funct3 function.
  - Misalignment-check function.
- Sub-module `lsu_extend`: combinational sign/zero extension of a split-assembled value, selected by funct3. Instantiated only under the macro.

## Test plan
Memory preload: dword 0 = 0x8877665544332211, dword 8 = 0xFFEEDDCCBBAA9900.

1. **Aligned loads.** LD addr 0 → `resp_rdata`=0x8877665544332211, exactly one `mem` cycle with width 011, `resp_valid` after E+1. LB addr 7 → 0xFFFFFFFFFFFFFF88; LBU addr 7 → 0x88.
2. **Store then load.** SW addr 0 wdata 0xAAAAAAAABBBBBBBB: `mem_we` high exactly one cycle, bus driven only then. Follow-up LD addr 0 → 0x88776655BBBBBBBB.
3. **Misaligned with macro.** LH addr 7 → two cycles, addr 7 then 8, width 100, result 0x0088. LW addr 6 → 0xFFFFFFFF99008877.
4. **Misaligned without macro.** LH addr 7 → `resp_fault`=1, `resp_rdata`=0, `mem_we` never asserted.
5. **Illegal requests and backpressure.** funct3=111 load → fault. SB-form store with funct3=100 → fault. `resp_ready` held low 5 cycles → `resp_valid`/`resp_rdata` stable throughout and `req_ready`=0.
6. **Reset mid-split.** `rst` pulsed during the 2nd byte of a split SH → `mem_we`=0 and bus high-Z immediately, no `resp_valid`, and `req_ready`=1 after release.
